ctrlport_cmd_initiator: RTL
===========================

# ctrlport_cmd_initiator

CtrlPort master that turns single read/write commands from a valid/ready command interface into CtrlPort request strobes, waits for the responder's acknowledgement (with timeout), and returns one response per command. It sits on the requesting side of a block's user-register bus. Typical uses are bring-up sequencers and register-test logic driving a CtrlPort register responder inside an RFNoC block. It carries exactly one outstanding transaction at a time.

## Interface
- TIMEOUT, default 1023: number of cycles to wait for `resp_ack` after the strobe cycle before reporting a timeout; must be ≥1.
- ctrlport_clk  in  1  only clock; every input and output is synchronous to it.
- ctrlport_rst  in  1  synchronous, active-high reset.
- s_cmd_wr  in  1  command type: 1 = write, 0 = read.
- s_cmd_addr  in  20  CtrlPort byte address.
- s_cmd_data  in  32  write data; ignored for reads.
- s_cmd_valid  in  1  command valid.
- s_cmd_ready  out  1  command accepted when `s_cmd_valid` and `s_cmd_ready` are both high.
- m_ctrlport_req_wr  out  1  one-cycle write strobe.
- m_ctrlport_req_rd  out  1  one-cycle read strobe.
- m_ctrlport_req_addr  out  20  request address.
- m_ctrlport_req_data  out  32  request write data.
- m_ctrlport_resp_ack  in  1  responder acknowledge.
- m_ctrlport_resp_data  in  32  read data; valid when `resp_ack` is high.
- m_rsp_valid  out  1  response valid.
- m_rsp_ready  in  1  response accepted.
- m_rsp_wr  out  1  echo of the command type.
- m_rsp_timeout  out  1  1 = no ack arrived within TIMEOUT cycles.
- m_rsp_data  out  32  read data; 0 for writes and for timeouts.
- busy  out  1  high in every state except IDLE.

## Operation
- FSM states are IDLE, STROBE, WAIT and RESP.
- IDLE:
  - `s_cmd_ready` = 1.
  - On accept, capture wr/addr/data into registers and go to STROBE.
- STROBE (exactly one cycle):
  - Assert `req_wr` or `req_rd` according to the captured type.
  - Clear the timeout counter, then go to WAIT.
- WAIT:
  - Strobes are 0; the counter increments once per cycle.
  - If `resp_ack` = 1: latch `resp_data` (reads) or 0 (writes), set timeout = 0, go to RESP.
  - Else if the counter reaches TIMEOUT: set data = 0, timeout = 1, go to RESP.
  - If ack arrives in the same cycle the counter reaches TIMEOUT, the ack wins (timeout = 0).
- RESP:
  - `m_rsp_valid` = 1; all `m_rsp_*` fields are held stable until `m_rsp_ready`.
  - On the handshake, go to IDLE.
- `resp_ack` is ignored outside WAIT: an ack in the STROBE cycle and late acks after a timeout are discarded.
- `req_addr`/`req_data` hold the captured command from STROBE through RESP. They keep their last value in IDLE; they are not re-zeroed.
- Counter width is $clog2(TIMEOUT+1) bits and it saturates, never wraps.
- Reset values: `s_cmd_ready`=0 while `ctrlport_rst`=1; all other outputs are 0. State returns to IDLE and all registers clear.
- Reset mid-transaction aborts it: no response is emitted, and a pending strobe is not issued.
- Commands presented while busy are not accepted (`s_cmd_ready`=0); the command source must hold them.

## Timing
- Command accepted in cycle N → strobe in cycle N+1 (registered, exactly 1 cycle wide).
- The ack window covers cycles N+2 … N+1+TIMEOUT.
- An ack in cycle M gives `m_rsp_valid` in cycle M+1. With a responder acking 1 cycle after the strobe, `m_rsp_valid` rises in cycle N+3.
- On timeout, `m_rsp_valid` rises in cycle N+2+TIMEOUT.
- A response handshake in cycle R gives IDLE in R+1, with `s_cmd_ready` high in R+1. Back-to-back throughput is therefore one command per 4 cycles minimum.
- `s_cmd_ready` and `busy` are decoded from registered state, with no combinational path from inputs.
- No combinational path exists from `m_rsp_ready` or `resp_ack` to any output.

## Structure
- Shared CtrlPort package/header provides the CtrlPort constants: address width 20 and data width 32.
- FSM state encodings are local to the module; they do not belong in a shared package.
- Single module; no sub-module needed. The timeout counter is a few lines of inline logic.

## Test plan
- Write addr 0x00000, data 0xDEADBEEF, responder acks 1 cycle later → `req_wr` high for exactly cycle N+1 with addr/data correct; response at N+3 with wr=1, timeout=0, data=0.
- Read addr 0x00000 after that write, responder returns 0xDEADBEEF → `req_rd` pulse at N+1; response data=0xDEADBEEF, timeout=0.
- TIMEOUT=8, read to an unmapped address (never acked) → `m_rsp_valid` at N+10 with timeout=1, data=0. An ack injected at N+12 is ignored, and the next command completes normally.
- Ack in the STROBE cycle only → ignored, ending in timeout. Ack on the last window cycle N+1+TIMEOUT → normal response, timeout=0.
- Hold `m_rsp_ready` low for 5 cycles with a new `s_cmd_valid` asserted → response fields stable and `s_cmd_ready`=0 throughout; the new command is accepted 1 cycle after the handshake.
- Assert `ctrlport_rst` in the cycle the command is accepted, and again during WAIT → no strobe and no `m_rsp_valid`; all outputs 0 the cycle after reset; `s_cmd_ready` returns to 1 the cycle after reset deasserts.

Source files
------------

// File: rtl/ctrlport_cmd_initiator_pkg.sv
// Shared CtrlPort bus constants and the command record used by CtrlPort masters.
package ctrlport_cmd_initiator_pkg;

    localparam int CTRLPORT_ADDR_W = 20;
    localparam int CTRLPORT_DATA_W = 32;

    typedef struct packed {
        logic                       wr;
        logic [CTRLPORT_ADDR_W-1:0] addr;
        logic [CTRLPORT_DATA_W-1:0] data;
    } ctrlport_cmd_t;

    typedef struct packed {
        logic                       wr;
        logic                       timeout;
        logic [CTRLPORT_DATA_W-1:0] data;
    } ctrlport_rsp_t;

endpackage

// File: rtl/ctrlport_cmd_initiator.sv
// CtrlPort master: one valid/ready command in, one strobe out, one response back.
// Only a single transaction is ever in flight; an unanswered request times out.
module ctrlport_cmd_initiator
    import ctrlport_cmd_initiator_pkg::*;
#(
    parameter int TIMEOUT = 1023
) (
    input  logic                       ctrlport_clk,
    input  logic                       ctrlport_rst,
    input  logic                       s_cmd_wr,
    input  logic [CTRLPORT_ADDR_W-1:0] s_cmd_addr,
    input  logic [CTRLPORT_DATA_W-1:0] s_cmd_data,
    input  logic                       s_cmd_valid,
    output logic                       s_cmd_ready,
    output logic                       m_ctrlport_req_wr,
    output logic                       m_ctrlport_req_rd,
    output logic [CTRLPORT_ADDR_W-1:0] m_ctrlport_req_addr,
    output logic [CTRLPORT_DATA_W-1:0] m_ctrlport_req_data,
    input  logic                       m_ctrlport_resp_ack,
    input  logic [CTRLPORT_DATA_W-1:0] m_ctrlport_resp_data,
    output logic                       m_rsp_valid,
    input  logic                       m_rsp_ready,
    output logic                       m_rsp_wr,
    output logic                       m_rsp_timeout,
    output logic [CTRLPORT_DATA_W-1:0] m_rsp_data,
    output logic                       busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam int                CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t          state;
    state_t          state_next;
    ctrlport_cmd_t   cmd;
    ctrlport_rsp_t   rsp;
    logic [CNT_W-1:0] cnt;
    logic            accept;
    logic            window_end;

    assign accept     = (state == IDLE) && s_cmd_valid;
    // The counter holds the number of WAIT cycles already spent, so the
    // final window cycle is the one where it reads TIMEOUT-1.
    assign window_end = (cnt >= CNT_LAST);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (s_cmd_valid) state_next = STROBE;
            STROBE:  state_next = WAIT;
            WAIT:    if (m_ctrlport_resp_ack || window_end) state_next = RESP;
            RESP:    if (m_rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge ctrlport_clk) begin
        if (ctrlport_rst) begin
            state <= IDLE;
            cmd   <= '0;
            rsp   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                cmd.wr   <= s_cmd_wr;
                cmd.addr <= s_cmd_addr;
                cmd.data <= s_cmd_data;
            end
            if (state == STROBE) begin
                cnt <= '0;
            end else if (state == WAIT && cnt != CNT_MAX) begin
                cnt <= cnt + CNT_W'(1);
            end
            // An ack on the last window cycle still counts as a normal response.
            if (state == WAIT) begin
                if (m_ctrlport_resp_ack) begin
                    rsp.wr      <= cmd.wr;
                    rsp.timeout <= 1'b0;
                    rsp.data    <= cmd.wr ? '0 : m_ctrlport_resp_data;
                end else if (window_end) begin
                    rsp.wr      <= cmd.wr;
                    rsp.timeout <= 1'b1;
                    rsp.data    <= '0;
                end
            end
        end
    end

    // Outputs come from registered state; reset only forces them quiet.
    assign s_cmd_ready         = (state == IDLE) && !ctrlport_rst;
    assign busy                = (state != IDLE);
    assign m_ctrlport_req_wr   = (state == STROBE) && cmd.wr && !ctrlport_rst;
    assign m_ctrlport_req_rd   = (state == STROBE) && !cmd.wr && !ctrlport_rst;
    assign m_ctrlport_req_addr = cmd.addr;
    assign m_ctrlport_req_data = cmd.data;
    assign m_rsp_valid         = (state == RESP) && !ctrlport_rst;
    assign m_rsp_wr            = rsp.wr;
    assign m_rsp_timeout       = rsp.timeout;
    assign m_rsp_data          = rsp.data;

endmodule
